// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: each channel has its own wrap counter,
// programmable period and mode (off/on/toggle/pulse), set through a one-cycle write port.
module led_blink_ctrl #(
    parameter int unsigned CH_NUM         = 4,
    parameter int unsigned CNT_W          = 25,
    parameter int unsigned DEFAULT_PERIOD = 24_999_999,
    parameter int unsigned CH_W           = 2
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              enable_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [CNT_W-1:0]  cfg_period_i,
    output logic              cfg_ack_o,
    output logic              cfg_err_o,
    output logic [CNT_W-1:0]  counter_o,
    output logic [CH_NUM-1:0] tick_o,
    output logic [CH_NUM-1:0] led_out_o
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_PULSE  = 2'd3
    } mode_e;

    mode_e             mode_q   [CH_NUM];
    mode_e             mode_d   [CH_NUM];
    logic [CNT_W-1:0]  period_q [CH_NUM];
    logic [CNT_W-1:0]  period_d [CH_NUM];
    logic [CNT_W-1:0]  cnt_q    [CH_NUM];
    logic [CNT_W-1:0]  cnt_d    [CH_NUM];
    logic [CH_NUM-1:0] tick_q, tick_d;
    logic [CH_NUM-1:0] led_q, led_d;
    logic              cfg_ack_q, cfg_ack_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_valid_c;
    logic [CH_NUM-1:0] wrap_c;
    logic [CH_NUM-1:0] sel_c;

    // Per-channel next state; an accepted write to a channel overrides its wrap.
    always_comb begin
        cfg_valid_c = (32'(cfg_ch_i) < CH_NUM);
        cfg_ack_d   = cfg_we_i & cfg_valid_c;
        cfg_err_d   = cfg_we_i & ~cfg_valid_c;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            tick_d[i]   = 1'b0;
            led_d[i]    = led_q[i];
            wrap_c[i]   = (cnt_q[i] == period_q[i]);
            sel_c[i]    = cfg_ack_d & (cfg_ch_i == CH_W'(i));
            if (sel_c[i]) begin
                mode_d[i]   = mode_e'(cfg_mode_i);
                period_d[i] = cfg_period_i;
                cnt_d[i]    = '0;
                led_d[i]    = (mode_e'(cfg_mode_i) == MODE_ON);
            end else if (enable_i) begin
                if (mode_q[i] == MODE_OFF) begin
                    cnt_d[i] = '0;
                    led_d[i] = 1'b0;
                end else begin
                    cnt_d[i]  = wrap_c[i] ? '0 : cnt_q[i] + CNT_W'(1);
                    tick_d[i] = wrap_c[i];
                    case (mode_q[i])
                        MODE_ON:     led_d[i] = 1'b1;
                        MODE_TOGGLE: led_d[i] = led_q[i] ^ wrap_c[i];
                        default:     led_d[i] = wrap_c[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                mode_q[i]   <= MODE_TOGGLE;
                period_q[i] <= CNT_W'(DEFAULT_PERIOD);
                cnt_q[i]    <= '0;
            end
            tick_q    <= '0;
            led_q     <= '0;
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            led_q     <= led_d;
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ack_o = cfg_ack_q;
    assign cfg_err_o = cfg_err_q;
    assign counter_o = cnt_q[0];
    assign tick_o    = tick_q;
    assign led_out_o = led_q;

endmodule
